// File: rtl/usb_host_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : usb_host_pkg
//  Purpose  : Shared definitions for the USB host token transmitter: token
//             PID codes, FSM state encoding and the token CRC5 helper.
//  Revision : 1.0  initial release
// ============================================================================
package usb_host_pkg;

   localparam logic [3:0] PID_OUT   = 4'h1;
   localparam logic [3:0] PID_IN    = 4'h9;
   localparam logic [3:0] PID_SOF   = 4'h5;
   localparam logic [3:0] PID_SETUP = 4'hD;
   localparam logic [3:0] PID_PING  = 4'h4;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PID  = 3'd1,
      ST_F0   = 3'd2,
      ST_F1   = 3'd3,
      ST_GAP  = 3'd4
   } state_t;

   // Token CRC5 (x^5+x^2+1, seed all ones, field taken LSB first, residual
   // inverted). The result is bit-reversed so that bit 0 is the CRC bit the
   // wire carries first; it drops straight into F1[7:3].
   function automatic logic [4:0] crc5(input logic [10:0] field);
      logic [4:0] c;
      logic [4:0] r;
      logic       fb;
      c = 5'h1F;
      for (int i = 0; i < 11; i++) begin
         fb = field[i] ^ c[4];
         c  = {c[3:0], 1'b0};
         if (fb) begin
            c = c ^ 5'b00101;
         end
      end
      c = ~c;
      for (int i = 0; i < 5; i++) begin
         r[i] = c[4-i];
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/usb_host_token_tx.sv
`default_nettype none
// ============================================================================
//  Module   : usb_host_token_tx
//  Purpose  : Host-side USB full-speed token generator on a UTMI TX port.
//             Sends an SOF every frame and SETUP/IN/OUT/PING tokens on
//             request as PID byte + 11-bit field + CRC5 (PHY adds SYNC/EOP).
//  Ports    : clk_i, rst_i (async, active-high)
//             enable_i, sof_enable_i          - host / SOF generation enables
//             req_valid_i/req_ready_o,
//             req_pid_i, req_addr_i, req_endp_i - token request handshake
//             busy_o, sof_o, frame_num_o       - status
//             utmi_data_out_o, utmi_txvalid_o,
//             utmi_txready_i                   - UTMI transmit port
//  Revision : 1.0  initial release
// ============================================================================
module usb_host_token_tx
   import usb_host_pkg::*;
#(
   parameter int SOF_PERIOD = 60000,
   parameter int SOF_GUARD  = 600,
   parameter int IPG_CYCLES = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        enable_i,
   input  logic        sof_enable_i,
   input  logic        req_valid_i,
   input  logic [3:0]  req_pid_i,
   input  logic [6:0]  req_addr_i,
   input  logic [3:0]  req_endp_i,
   output logic        req_ready_o,
   output logic        busy_o,
   output logic        sof_o,
   output logic [10:0] frame_num_o,
   output logic [7:0]  utmi_data_out_o,
   output logic        utmi_txvalid_o,
   input  logic        utmi_txready_i
);

   localparam int TMR_W = $clog2(SOF_PERIOD);
   localparam int GAP_W = $clog2(IPG_CYCLES + 1);

   localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(SOF_PERIOD - 1);
   localparam logic [TMR_W-1:0] TMR_GUARD  = TMR_W'(SOF_GUARD);
   localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(IPG_CYCLES - 1);

   state_t             state_q, state_d;
   logic [3:0]         pid_q, pid_d;
   logic [10:0]        field_q, field_d;
   logic               is_sof_q, is_sof_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic [TMR_W-1:0]   timer_q;
   logic               sof_pending_q;
   logic [10:0]        frame_q;
   logic               sof_q;
   logic               sof_done;

   // Requests are refused close to a frame boundary so a token never
   // delays the SOF; reset also forces the handshake low.
   assign req_ready_o = !rst_i && (state_q == ST_IDLE) && enable_i &&
                        !sof_pending_q && (timer_q >= TMR_GUARD);
   assign busy_o      = (state_q != ST_IDLE);
   assign sof_o       = sof_q;
   assign frame_num_o = frame_q;

   always_comb begin
      state_d         = state_q;
      pid_d           = pid_q;
      field_d         = field_q;
      is_sof_d        = is_sof_q;
      gap_d           = gap_q;
      sof_done        = 1'b0;
      utmi_txvalid_o  = 1'b0;
      utmi_data_out_o = 8'h00;
      case (state_q)
         ST_IDLE: begin
            gap_d = '0;
            // A due SOF wins over a simultaneous token request.
            if (enable_i && sof_pending_q) begin
               pid_d    = PID_SOF;
               field_d  = frame_q;
               is_sof_d = 1'b1;
               state_d  = ST_PID;
            end else if (req_valid_i && req_ready_o) begin
               pid_d    = req_pid_i;
               field_d  = {req_endp_i, req_addr_i};
               is_sof_d = 1'b0;
               state_d  = ST_PID;
            end
         end
         ST_PID: begin
            utmi_txvalid_o  = 1'b1;
            utmi_data_out_o = {~pid_q, pid_q};
            if (utmi_txready_i) state_d = ST_F0;
         end
         ST_F0: begin
            utmi_txvalid_o  = 1'b1;
            utmi_data_out_o = field_q[7:0];
            if (utmi_txready_i) state_d = ST_F1;
         end
         ST_F1: begin
            utmi_txvalid_o  = 1'b1;
            utmi_data_out_o = {crc5(field_q), field_q[10:8]};
            if (utmi_txready_i) begin
               state_d  = ST_GAP;
               sof_done = is_sof_q;
            end
         end
         ST_GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         pid_q    <= 4'h0;
         field_q  <= 11'h000;
         is_sof_q <= 1'b0;
         gap_q    <= '0;
      end else begin
         state_q  <= state_d;
         pid_q    <= pid_d;
         field_q  <= field_d;
         is_sof_q <= is_sof_d;
         gap_q    <= gap_d;
      end
   end

   // Frame timer and SOF bookkeeping. An expiry landing while an SOF is
   // still owed keeps the flag set rather than queueing a second SOF.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         timer_q       <= TMR_RELOAD;
         sof_pending_q <= 1'b0;
         frame_q       <= 11'h000;
         sof_q         <= 1'b0;
      end else begin
         sof_q <= sof_done;
         if (sof_done) begin
            frame_q <= frame_q + 11'd1;
         end
         if (!(enable_i && sof_enable_i)) begin
            timer_q       <= TMR_RELOAD;
            sof_pending_q <= 1'b0;
         end else begin
            if (sof_done) begin
               sof_pending_q <= 1'b0;
            end
            if (timer_q == '0) begin
               timer_q       <= TMR_RELOAD;
               sof_pending_q <= 1'b1;
            end else begin
               timer_q <= timer_q - TMR_W'(1);
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_usb_host_token_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_usb_host_token_tx
//  Purpose  : Directed self-checking bench for usb_host_token_tx. A second,
//             short-period instance is used to walk the frame number to its
//             wrap point within a reasonable cycle count.
//  Revision : 1.0  initial release
// ============================================================================
module tb_usb_host_token_tx;

   logic        clk = 1'b0;
   logic        rst;
   logic        en, sof_en, req_valid, txready;
   logic [3:0]  req_pid;
   logic [6:0]  req_addr;
   logic [3:0]  req_endp;
   logic        ready, busy, sof, txvalid;
   logic [10:0] frame;
   logic [7:0]  data;

   logic        w_en, w_sof_en, w_req_valid, w_txready;
   logic        w_ready, w_busy, w_sof, w_txvalid;
   logic [10:0] w_frame;
   logic [7:0]  w_data;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   usb_host_token_tx #(.SOF_PERIOD(200), .SOF_GUARD(30), .IPG_CYCLES(16)) u_dut (
      .clk_i(clk), .rst_i(rst), .enable_i(en), .sof_enable_i(sof_en),
      .req_valid_i(req_valid), .req_pid_i(req_pid), .req_addr_i(req_addr),
      .req_endp_i(req_endp), .req_ready_o(ready), .busy_o(busy), .sof_o(sof),
      .frame_num_o(frame), .utmi_data_out_o(data), .utmi_txvalid_o(txvalid),
      .utmi_txready_i(txready)
   );

   usb_host_token_tx #(.SOF_PERIOD(24), .SOF_GUARD(4), .IPG_CYCLES(16)) u_wrap (
      .clk_i(clk), .rst_i(rst), .enable_i(w_en), .sof_enable_i(w_sof_en),
      .req_valid_i(w_req_valid), .req_pid_i(4'h0), .req_addr_i(7'h00),
      .req_endp_i(4'h0), .req_ready_o(w_ready), .busy_o(w_busy), .sof_o(w_sof),
      .frame_num_o(w_frame), .utmi_data_out_o(w_data), .utmi_txvalid_o(w_txvalid),
      .utmi_txready_i(w_txready)
   );

   // Reflected-register CRC5 (poly 0x14 shifting right); the complemented
   // register is already in wire order, i.e. the F1[7:3] layout.
   function automatic logic [7:0] ref_f1(input logic [10:0] f);
      logic [4:0] r;
      r = 5'h1F;
      for (int i = 0; i < 11; i++) begin
         if (r[0] ^ f[i]) r = (r >> 1) ^ 5'h14;
         else             r = r >> 1;
      end
      return {~r, f[10:8]};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; en = 1'b1; sof_en = 1'b1; req_valid = 1'b1; txready = 1'b1;
      req_pid = 4'hD; req_addr = 7'h00; req_endp = 4'h0;
      w_en = 1'b1; w_sof_en = 1'b0; w_req_valid = 1'b0; w_txready = 1'b1;
      repeat (3) tick();
      n_checks++;
      if ({ready, busy, sof, txvalid, data, frame} !== 23'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got ready=%b busy=%b sof=%b txvalid=%b data=%h frame=%h, want all 0",
                  ready, busy, sof, txvalid, data, frame);
      end
      req_valid = 1'b0; sof_en = 1'b0;
      rst = 1'b0;
      tick();
      n_checks++;
      if (ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: got ready=%b busy=%b, want ready=1 busy=0", ready, busy);
      end
   endtask

   task automatic test_setup;
      logic [7:0] exp [3];
      logic       bad;
      exp = '{8'h2D, 8'h00, 8'h10};
      req_valid = 1'b1; req_pid = 4'hD; req_addr = 7'h00; req_endp = 4'h0; txready = 1'b1;
      tick();
      req_valid = 1'b0;
      for (int b = 0; b < 3; b++) begin
         n_checks++;
         if (txvalid !== 1'b1 || data !== exp[b]) begin
            n_fail++;
            $display("FAIL setup_byte%0d: got valid=%b data=%h, want valid=1 data=%h", b, txvalid, data, exp[b]);
         end
         tick();
      end
      bad = 1'b0;
      for (int k = 0; k < 16; k++) begin
         if (ready !== 1'b0 || txvalid !== 1'b0 || data !== 8'h00) bad = 1'b1;
         if (k < 15) tick();
      end
      n_checks++;
      if (bad) begin
         n_fail++;
         $display("FAIL setup_gap: ready/txvalid/data nonzero within 16 gap cycles, want 0");
      end
      tick();
      n_checks++;
      if (ready !== 1'b1) begin
         n_fail++;
         $display("FAIL setup_gap_end: got ready=%b, want 1", ready);
      end
   endtask

   task automatic test_in_slow;
      logic [7:0] exp [3];
      logic       bad;
      exp = '{8'h69, 8'h00, 8'h10};
      txready = 1'b0;
      req_valid = 1'b1; req_pid = 4'h9; req_addr = 7'h00; req_endp = 4'h0;
      tick();
      req_valid = 1'b0;
      for (int b = 0; b < 3; b++) begin
         bad = 1'b0;
         for (int k = 0; k < 8; k++) begin
            txready = (k == 7);
            if (txvalid !== 1'b1 || data !== exp[b]) bad = 1'b1;
            tick();
         end
         txready = 1'b0;
         n_checks++;
         if (bad) begin
            n_fail++;
            $display("FAIL in_slow_byte%0d: byte not held at %h (last data=%h valid=%b)", b, exp[b], data, txvalid);
         end
      end
      n_checks++;
      if (txvalid !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL in_slow_end: got txvalid=%b busy=%b, want txvalid=0 busy=1", txvalid, busy);
      end
      txready = 1'b1;
   endtask

   task automatic test_sof;
      int n;
      int last;
      last = 0;
      sof_en = 1'b1;
      for (int f = 0; f < 3; f++) begin
         n = 0;
         while (txvalid !== 1'b1 && n < 300) begin
            tick();
            n++;
         end
         if (f == 0) begin
            n_checks++;
            if (n != 201) begin
               n_fail++;
               $display("FAIL sof_first_latency: got %0d cycles, want 201", n);
            end
         end
         n_checks++;
         if (data !== 8'hA5) begin
            n_fail++;
            $display("FAIL sof%0d_pid: got %h, want a5", f, data);
         end
         tick();
         n_checks++;
         if (data !== 8'(f)) begin
            n_fail++;
            $display("FAIL sof%0d_f0: got %h, want %h", f, data, 8'(f));
         end
         tick();
         n_checks++;
         if (data !== ref_f1(11'(f))) begin
            n_fail++;
            $display("FAIL sof%0d_f1: got %h, want %h", f, data, ref_f1(11'(f)));
         end
         tick();
         n_checks++;
         if (sof !== 1'b1 || frame !== 11'(f + 1)) begin
            n_fail++;
            $display("FAIL sof%0d_pulse: got sof=%b frame=%0d, want sof=1 frame=%0d", f, sof, frame, f + 1);
         end
         if (f > 0) begin
            n_checks++;
            if (cyc - last != 200) begin
               n_fail++;
               $display("FAIL sof%0d_period: got %0d cycles, want 200", f, cyc - last);
            end
         end
         last = cyc;
      end
   endtask

   task automatic test_guard;
      int   n;
      logic seen_ready;
      repeat (165) tick();
      n_checks++;
      if (ready !== 1'b1) begin
         n_fail++;
         $display("FAIL guard_edge_open: got ready=%b, want 1", ready);
      end
      tick();
      n_checks++;
      if (ready !== 1'b0) begin
         n_fail++;
         $display("FAIL guard_edge_closed: got ready=%b, want 0", ready);
      end
      req_valid = 1'b1; req_pid = 4'h1; req_addr = 7'h15; req_endp = 4'hE;
      n = 0; seen_ready = 1'b0;
      while (txvalid !== 1'b1 && n < 100) begin
         if (ready === 1'b1) seen_ready = 1'b1;
         tick();
         n++;
      end
      n_checks++;
      if (n != 31 || seen_ready || data !== 8'hA5) begin
         n_fail++;
         $display("FAIL guard_sof_first: got wait=%0d ready_seen=%b data=%h, want wait=31 ready_seen=0 data=a5",
                  n, seen_ready, data);
      end
      tick();
      tick();
      n_checks++;
      if (data !== ref_f1(11'd3)) begin
         n_fail++;
         $display("FAIL guard_sof_f1: got %h, want %h", data, ref_f1(11'd3));
      end
      tick();
      n = 0;
      while (txvalid !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      req_valid = 1'b0;
      n_checks++;
      if (n != 17 || data !== 8'hE1) begin
         n_fail++;
         $display("FAIL guard_req_after: got wait=%0d data=%h, want wait=17 data=e1", n, data);
      end
      tick();
      n_checks++;
      if (data !== 8'h15) begin
         n_fail++;
         $display("FAIL guard_req_f0: got %h, want 15", data);
      end
      tick();
      n_checks++;
      if (data !== ref_f1({4'hE, 7'h15})) begin
         n_fail++;
         $display("FAIL guard_req_f1: got %h, want %h", data, ref_f1({4'hE, 7'h15}));
      end
      tick();
   endtask

   task automatic test_enable_drop;
      int   n;
      logic bad;
      n = 0;
      while (ready !== 1'b1 && n < 60) begin
         tick();
         n++;
      end
      req_valid = 1'b1; req_pid = 4'h9; req_addr = 7'h7F; req_endp = 4'hF;
      tick();
      en = 1'b0;
      n_checks++;
      if (data !== 8'h69) begin
         n_fail++;
         $display("FAIL drop_pid: got %h, want 69", data);
      end
      tick();
      n_checks++;
      if (data !== 8'hFF) begin
         n_fail++;
         $display("FAIL drop_f0: got %h, want ff", data);
      end
      tick();
      n_checks++;
      if (txvalid !== 1'b1 || data !== ref_f1(11'h7FF)) begin
         n_fail++;
         $display("FAIL drop_f1: got valid=%b data=%h, want valid=1 data=%h", txvalid, data, ref_f1(11'h7FF));
      end
      bad = 1'b0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (txvalid !== 1'b0 || ready !== 1'b0) bad = 1'b1;
      end
      n_checks++;
      if (bad || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL drop_idle: got activity=%b busy=%b, want activity=0 busy=0", bad, busy);
      end
      req_valid = 1'b0;
      en = 1'b1;
      tick();
   endtask

   task automatic test_reset_mid;
      int n;
      req_valid = 1'b1; req_pid = 4'hD; req_addr = 7'h01; req_endp = 4'h0;
      tick();
      req_valid = 1'b0;
      tick();
      n_checks++;
      if (txvalid !== 1'b1 || data !== 8'h01) begin
         n_fail++;
         $display("FAIL rstmid_f0: got valid=%b data=%h, want valid=1 data=01", txvalid, data);
      end
      #1 rst = 1'b1;
      #1;
      n_checks++;
      if (txvalid !== 1'b0 || data !== 8'h00 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_drop: got valid=%b data=%h busy=%b, want 0", txvalid, data, busy);
      end
      tick();
      tick();
      rst = 1'b0;
      n_checks++;
      if (frame !== 11'd0) begin
         n_fail++;
         $display("FAIL rstmid_frame: got %0d, want 0", frame);
      end
      n = 0;
      while (txvalid !== 1'b1 && n < 300) begin
         tick();
         n++;
      end
      n_checks++;
      if (n != 201 || data !== 8'hA5) begin
         n_fail++;
         $display("FAIL rstmid_sof: got wait=%0d data=%h, want wait=201 data=a5", n, data);
      end
      tick();
      tick();
      n_checks++;
      if (data !== 8'h10) begin
         n_fail++;
         $display("FAIL rstmid_sof_f1: got %h, want 10", data);
      end
      tick();
   endtask

   task automatic test_wrap;
      int n;
      int cnt;
      w_sof_en = 1'b1;
      n = 0; cnt = 0;
      while (cnt < 2047 && n < 60000) begin
         tick();
         n++;
         if (w_sof === 1'b1) cnt++;
      end
      n_checks++;
      if (cnt != 2047 || w_frame !== 11'h7FF) begin
         n_fail++;
         $display("FAIL wrap_preset: got sofs=%0d frame=%h, want sofs=2047 frame=7ff", cnt, w_frame);
      end
      n = 0;
      while (w_txvalid !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      n_checks++;
      if (w_data !== 8'hA5) begin
         n_fail++;
         $display("FAIL wrap_pid: got %h, want a5", w_data);
      end
      tick();
      n_checks++;
      if (w_data !== 8'hFF) begin
         n_fail++;
         $display("FAIL wrap_f0: got %h, want ff", w_data);
      end
      tick();
      n_checks++;
      if (w_data !== ref_f1(11'h7FF)) begin
         n_fail++;
         $display("FAIL wrap_f1: got %h, want %h", w_data, ref_f1(11'h7FF));
      end
      tick();
      n_checks++;
      if (w_sof !== 1'b1 || w_frame !== 11'd0) begin
         n_fail++;
         $display("FAIL wrap_to_zero: got sof=%b frame=%h, want sof=1 frame=000", w_sof, w_frame);
      end
      n = 0;
      while (w_txvalid !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      tick();
      n_checks++;
      if (w_data !== 8'h00) begin
         n_fail++;
         $display("FAIL wrap_next_f0: got %h, want 00", w_data);
      end
      tick();
      n_checks++;
      if (w_data !== 8'h10) begin
         n_fail++;
         $display("FAIL wrap_next_f1: got %h, want 10", w_data);
      end
   endtask

   initial begin
      test_reset();
      test_setup();
      test_in_slow();
      test_sof();
      test_guard();
      test_enable_drop();
      test_reset_mid();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
